// File: rtl/halfband_decim_ts_multi_pkg.sv
// Shared constants, mode/sequencer encodings and the round/saturate helper for the
// time-shared halfband decimator.
package halfband_decim_ts_multi_pkg;

  localparam int unsigned DefDw  = 18;
  localparam int unsigned DefCw  = 18;
  localparam int unsigned DefK   = 2;
  localparam int unsigned DefNch = 2;
  // Pre-adder growth bit plus one headroom bit for the centre term and rounding.
  localparam int unsigned GuardBits = 2;
  localparam int unsigned SatW = 64;

  typedef enum logic {ModeFilter = 1'b0, ModeBypass = 1'b1} mode_e;

  typedef enum logic [1:0] {StIdle, StMac, StFin} seq_state_e;

  // Round half up, arithmetic shift right by 'shift', clamp to a signed 'width'-bit range.
  function automatic logic signed [SatW-1:0] sat_round(input logic signed [SatW-1:0] acc,
                                                       input int unsigned shift,
                                                       input int unsigned width);
    logic signed [SatW-1:0] one, r, hi, lo;
    one = SatW'(1);
    r   = (acc + (one <<< (shift - 1))) >>> shift;
    hi  = (one <<< (width - 1)) - one;
    lo  = -hi - one;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/halfband_decim_ts_multi_if.sv
// Sample, coefficient-load and result signals of the halfband decimator.
interface halfband_decim_ts_multi_if
  import halfband_decim_ts_multi_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned CW  = DefCw,
  parameter int unsigned K   = DefK,
  parameter int unsigned NCH = DefNch
);
  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;

  logic              in_valid;
  logic [NCH*DW-1:0] x_in;
  logic              mode;
  logic              coef_wr;
  logic [AW-1:0]     coef_addr;
  logic [CW-1:0]     coef_data;
  logic              out_valid;
  logic [NCH*DW-1:0] y_out;
  logic              overrun;

  modport master (
    output in_valid, x_in, mode, coef_wr, coef_addr, coef_data,
    input  out_valid, y_out, overrun
  );

  modport slave (
    input  in_valid, x_in, mode, coef_wr, coef_addr, coef_data,
    output out_valid, y_out, overrun
  );

endinterface

// File: rtl/halfband_decim_ts_multi_mac.sv
// Shared pre-adder, multiplier and accumulator; res_o is the rounded, saturated sum of
// the accumulator and the half-gain centre term.
module halfband_decim_ts_multi_mac
  import halfband_decim_ts_multi_pkg::*;
#(
  parameter int unsigned DW   = DefDw,
  parameter int unsigned CW   = DefCw,
  parameter int unsigned AccW = DW + 1 + CW + GuardBits
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mul_en_i,
  input  logic                 load_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] centre_i,
  output logic signed [DW-1:0] res_o
);
  localparam int unsigned PW = DW + CW + 1;

  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [AccW-1:0] acc_d, acc_q, fin;

  always_comb begin
    pre   = (DW + 1)'(a_i) + (DW + 1)'(b_i);
    prod  = PW'(pre) * PW'(coef_i);
    acc_d = acc_q;
    if (mul_en_i) begin
      acc_d = load_i ? AccW'(prod) : acc_q + AccW'(prod);
    end
    fin   = acc_q + (AccW'(centre_i) <<< (CW - 1));
    res_o = DW'(sat_round(SatW'(fin), CW, DW));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/halfband_decim_ts_multi.sv
// NCH-channel decimate-by-2 halfband FIR with one MAC shared over (channel, coefficient)
// pairs, double-banked coefficients, bypass mode and sticky overrun.
module halfband_decim_ts_multi
  import halfband_decim_ts_multi_pkg::*;
#(
  parameter int unsigned     DW        = DefDw,
  parameter int unsigned     CW        = DefCw,
  parameter int unsigned     K         = DefK,
  parameter int unsigned     NCH       = DefNch,
  parameter logic [K*CW-1:0] COEF_INIT = {18'h3DBFC, 18'h124A8}
) (
  input  logic                      clk,
  input  logic                      reset_n,
  halfband_decim_ts_multi_if.slave  bus
);
  localparam int unsigned AccW = DW + 1 + CW + $clog2(K) + 1;
  localparam int unsigned KW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned ChW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned OW   = (K > 1) ? $clog2(2 * K) : 1;

  seq_state_e state_d, state_q;
  logic [ChW-1:0] ch_d, ch_q, fin_ch;
  logic [KW-1:0]  k_d, k_q;
  logic [OW-1:0]  kmir;
  logic ovr_d, ovr_q, outv_d, outv_q, phase_d, phase_q;
  mode_e mode_q;
  logic mode_chg, accept, p0, p1, start, byp1, busy;
  logic mul_en, load, cap_res, upd_y;

  logic signed [DW-1:0] xo_q  [NCH][2*K];
  logic signed [DW-1:0] xc_q  [NCH][K];
  logic signed [DW-1:0] xcs_q [NCH];
  logic signed [DW-1:0] res_q [NCH];
  logic signed [DW-1:0] y_q   [NCH];
  logic signed [CW-1:0] act_q [K];
  logic signed [CW-1:0] sh_q  [K];
  logic signed [DW-1:0] mac_res;

  // A mode change swallows any in_valid of the same cycle.
  assign mode_chg = (mode_e'(bus.mode) != mode_q);
  assign accept   = bus.in_valid && !mode_chg;
  assign p0       = accept && !phase_q;
  assign p1       = accept && phase_q;
  assign start    = p1 && (mode_q == ModeFilter);
  assign byp1     = p1 && (mode_q == ModeBypass);
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    k_d     = k_q;
    ovr_d   = ovr_q;
    outv_d  = 1'b0;
    phase_d = phase_q;
    mul_en  = 1'b0;
    load    = 1'b0;
    cap_res = 1'b0;
    upd_y   = 1'b0;
    if (mode_chg) begin
      state_d = StIdle;
      ch_d    = '0;
      k_d     = '0;
      ovr_d   = 1'b0;
      phase_d = 1'b0;
    end else begin
      if (accept) phase_d = ~phase_q;
      if (byp1) outv_d = 1'b1;
      if (start) begin
        if (busy) ovr_d = 1'b1;
        state_d = StMac;
        ch_d    = '0;
        k_d     = '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StMac: begin
            mul_en  = 1'b1;
            load    = (k_q == '0);
            // Loading the next channel is the moment the previous channel's sum is final.
            cap_res = (k_q == '0) && (ch_q != '0);
            if (k_q == KW'(K - 1)) begin
              k_d = '0;
              if (ch_q == ChW'(NCH - 1)) state_d = StFin;
              else                       ch_d    = ch_q + ChW'(1);
            end else begin
              k_d = k_q + KW'(1);
            end
          end
          StFin: begin
            upd_y   = 1'b1;
            outv_d  = 1'b1;
            state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    fin_ch = ch_q;
    if (state_q == StMac && ch_q != '0) fin_ch = ch_q - ChW'(1);
    kmir = OW'(2 * K - 1) - OW'(k_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ch_q    <= '0;
      k_q     <= '0;
      ovr_q   <= 1'b0;
      outv_q  <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= ModeFilter;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      k_q     <= k_d;
      ovr_q   <= ovr_d;
      outv_q  <= outv_d;
      phase_q <= phase_d;
      mode_q  <= mode_e'(bus.mode);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 2 * K; t++) xo_q[c][t] <= '0;
        for (int t = 0; t < K; t++)     xc_q[c][t] <= '0;
        xcs_q[c] <= '0;
        res_q[c] <= '0;
        y_q[c]   <= '0;
      end
      for (int k = 0; k < K; k++) begin
        act_q[k] <= COEF_INIT[(K - 1 - k) * CW +: CW];
        sh_q[k]  <= COEF_INIT[(K - 1 - k) * CW +: CW];
      end
    end else begin
      if (bus.coef_wr && (32'(bus.coef_addr) < K)) sh_q[bus.coef_addr] <= bus.coef_data;
      if (start) act_q <= sh_q;
      for (int c = 0; c < NCH; c++) begin
        if (p0) begin
          xc_q[c][0] <= $signed(bus.x_in[c*DW +: DW]);
          for (int t = 1; t < K; t++) xc_q[c][t] <= xc_q[c][t-1];
        end
        if (p1) begin
          xo_q[c][0] <= $signed(bus.x_in[c*DW +: DW]);
          for (int t = 1; t < 2 * K; t++) xo_q[c][t] <= xo_q[c][t-1];
        end
        // Centre taps are frozen at start since phase-0 samples keep arriving mid-sequence.
        if (start) xcs_q[c] <= xc_q[c][K-1];
        if (byp1)  y_q[c]   <= xc_q[c][0];
        if (upd_y) y_q[c]   <= (c == NCH - 1) ? mac_res : res_q[c];
      end
      if (cap_res) res_q[fin_ch] <= mac_res;
    end
  end

  halfband_decim_ts_multi_mac #(
    .DW   (DW),
    .CW   (CW),
    .AccW (AccW)
  ) u_mac (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .mul_en_i (mul_en),
    .load_i   (load),
    .a_i      (xo_q[ch_q][OW'(k_q)]),
    .b_i      (xo_q[ch_q][kmir]),
    .coef_i   (act_q[k_q]),
    .centre_i (xcs_q[fin_ch]),
    .res_o    (mac_res)
  );

  assign bus.out_valid = outv_q;
  assign bus.overrun   = ovr_q;
  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign bus.y_out[c*DW +: DW] = y_q[c];
  end

endmodule

// File: tb/tb_halfband_decim_ts_multi.sv
// Directed bench for the halfband decimator: impulse responses, saturation, overrun,
// coefficient bank switching, bypass and mid-sequence reset.
module tb_halfband_decim_ts_multi;
  import halfband_decim_ts_multi_pkg::*;

  localparam int unsigned DW  = 18;
  localparam int unsigned CW  = 18;
  localparam int unsigned K   = 2;
  localparam int unsigned NCH = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  halfband_decim_ts_multi_if #(.DW(DW), .CW(CW), .K(K), .NCH(NCH)) bus ();

  halfband_decim_ts_multi #(.DW(DW), .CW(CW), .K(K), .NCH(NCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input longint a0, input longint b0, input longint a1,
                           input longint b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.x_in     = {DW'(b0), DW'(a0)};
    @(posedge clk); #1;
    bus.x_in     = {DW'(b1), DW'(a1)};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
  endtask

  // Cycles counted from the cycle after the phase-1 in_valid; -1 if nothing within budget.
  task automatic wait_out(input bit do_wr, output int lat, output longint y0,
                          output longint y1);
    lat = -1;
    y0  = 0;
    y1  = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (do_wr && n == 2) begin
        bus.coef_wr   = 1'b1;
        bus.coef_addr = 1'b1;
        bus.coef_data = '0;
      end
      if (do_wr && n == 3) bus.coef_wr = 1'b0;
      if (bus.out_valid) begin
        lat = n;
        y0  = $signed(bus.y_out[DW-1:0]);
        y1  = $signed(bus.y_out[2*DW-1:DW]);
        break;
      end
    end
  endtask

  task automatic run_pair(input string tag, input longint a0, input longint b0,
                          input longint a1, input longint b1, input longint e0,
                          input longint e1, input int elat, input bit do_wr);
    int     lat;
    longint y0, y1;
    send_pair(a0, b0, a1, b1);
    wait_out(do_wr, lat, y0, y1);
    check_val({tag, "_lat"}, lat, elat);
    check_val({tag, "_ch0"}, y0, e0);
    check_val({tag, "_ch1"}, y1, e1);
  endtask

  task automatic fill_pair(input longint v);
    int     lat;
    longint y0, y1;
    send_pair(v, v, v, v);
    wait_out(1'b0, lat, y0, y1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ov_cnt;
    int lat;
    longint y0, y1;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.mode      = 1'b0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    repeat (3) @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.x_in      = {DW'(777), DW'(555)};
    @(negedge clk);
    check_val("rst_y0", $signed(bus.y_out[DW-1:0]), 0);
    check_val("rst_y1", $signed(bus.y_out[2*DW-1:DW]), 0);
    check_val("rst_ovalid", bus.out_valid, 0);
    check_val("rst_overrun", bus.overrun, 0);
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Phase-1 impulse on ch0: odd-branch taps h0,h1,h1,h0 then silence.
    run_pair("imp1_a", 0, 0, 65536, 0, -2305, 0, 6, 1'b0);
    run_pair("imp1_b", 0, 0, 0, 0, 18730, 0, 6, 1'b0);
    run_pair("imp1_c", 0, 0, 0, 0, 18730, 0, 6, 1'b0);
    run_pair("imp1_d", 0, 0, 0, 0, -2305, 0, 6, 1'b0);
    run_pair("imp1_e", 0, 0, 0, 0, 0, 0, 6, 1'b0);

    // Phase-0 impulse on ch1 reaches the centre tap one output later.
    run_pair("imp0_a", 0, 65536, 0, 0, 0, 0, 6, 1'b0);
    run_pair("imp0_b", 0, 0, 0, 0, 0, 32768, 6, 1'b0);
    run_pair("imp0_c", 0, 0, 0, 0, 0, 0, 6, 1'b0);

    repeat (3) fill_pair(131071);
    run_pair("dc_pos", 131071, 131071, 131071, 131071, 131071, 131071, 6, 1'b0);
    repeat (3) fill_pair(-131072);
    run_pair("dc_neg", -131072, -131072, -131072, -131072, -131072, -131072, 6, 1'b0);

    // Shadow write of h1=0 during a sequence only affects the following output.
    repeat (4) fill_pair(0);
    run_pair("cw_a", 0, 0, 65536, 0, -2305, 0, 6, 1'b0);
    run_pair("cw_b", 0, 0, 0, 0, 18730, 0, 6, 1'b1);
    run_pair("cw_c", 0, 0, 0, 0, 0, 0, 6, 1'b0);
    run_pair("cw_d", 0, 0, 0, 0, -2305, 0, 6, 1'b0);
    @(negedge clk);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 1'b1;
    bus.coef_data = 18'h124A8;
    @(negedge clk);
    bus.coef_wr   = 1'b0;

    // in_valid every clock: every later phase-1 collides with a busy MAC.
    ov_cnt = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_out(1'b0, lat, y0, y1);
    check_val("ovr_no_out", ov_cnt, 0);
    check_val("ovr_last_lat", lat, 6);
    check_val("ovr_sticky", bus.overrun, 1);

    @(posedge clk); #1;
    bus.mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("mode_clr_ovr", bus.overrun, 0);

    run_pair("byp_a", 0, 100, 1, 101, 0, 100, 1, 1'b0);
    run_pair("byp_b", 2, 102, 3, 103, 2, 102, 1, 1'b0);
    run_pair("byp_c", 4, 104, 5, 105, 4, 104, 1, 1'b0);

    @(posedge clk); #1;
    bus.mode = 1'b0;
    @(posedge clk);
    send_pair(1000, 1000, 1000, 1000);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mrst_y0", $signed(bus.y_out[DW-1:0]), 0);
    check_val("mrst_y1", $signed(bus.y_out[2*DW-1:DW]), 0);
    check_val("mrst_ovalid", bus.out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ov_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check_val("mrst_discard", ov_cnt, 0);
    run_pair("mrst_phase", 0, 0, 65536, 0, -2305, 0, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
